// File: rtl/dmem_io_bridge_if.sv
// Bus bundle between the processor data port, data RAM, event FIFO consumer and board I/O.
// slave: bridge side; master: environment side (CPU, RAM, consumer, board).
interface dmem_io_bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wren;
    logic [31:0] cpu_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [31:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] leds;
    logic [15:0] switches;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wren, ram_q, evt_ready, switches,
        output cpu_rdata, ram_addr, ram_wdata, ram_wren, evt_data, evt_valid, leds
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wren, ram_q, evt_ready, switches,
        input  cpu_rdata, ram_addr, ram_wdata, ram_wren, evt_data, evt_valid, leds
    );
endinterface

// File: rtl/dmem_io_bridge.sv
// Data-memory bridge: RAM pass-through plus EVENT FIFO, LED, SWITCH, TIMER, STATUS registers.
// Ports: clock, reset (sync, active-high), bus (slave modport of dmem_io_bridge_if).
module dmem_io_bridge (
    input  logic            clock,
    input  logic            reset,
    dmem_io_bridge_if.slave bus
);
    logic is_ram, is_evt, is_led, is_sw, is_tmr, is_stat;

    logic [31:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [15:0] leds_q, leds_d;
    logic [15:0] sync1_q, sync2_q;
    logic [31:0] timer_q, timer_d;
    logic        sel_ram_q, sel_ram_d;
    logic [31:0] rd_val_q, rd_val_d;

    logic push_req, push, pop, drop, full, empty;

    always_comb begin
        is_ram  = (bus.cpu_addr[31:12] == 20'h0);
        is_evt  = (bus.cpu_addr == 32'h0000_1000);
        is_led  = (bus.cpu_addr == 32'h0000_1001);
        is_sw   = (bus.cpu_addr == 32'h0000_1002);
        is_tmr  = (bus.cpu_addr == 32'h0000_1003);
        is_stat = (bus.cpu_addr == 32'h0000_1004);
    end

    assign bus.ram_addr  = bus.cpu_addr[11:0];
    assign bus.ram_wdata = bus.cpu_wdata;
    assign bus.ram_wren  = bus.cpu_wren & is_ram;

    assign full          = (count_q == 3'd4);
    assign empty         = (count_q == 3'd0);
    assign bus.evt_valid = ~empty;
    assign bus.evt_data  = empty ? 32'h0 : fifo_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // only drops when nothing is being consumed.
    assign push_req = bus.cpu_wren & is_evt;
    assign pop      = ~empty & bus.evt_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {1'b0, push};
        rd_ptr_d  = rd_ptr_q + {1'b0, pop};
        count_d   = count_q + {2'b0, push} - {2'b0, pop};
        ovf_d     = ovf_q;
        leds_d    = leds_q;
        timer_d   = timer_q + 32'd1;
        sel_ram_d = is_ram;
        rd_val_d  = 32'h0;

        if (bus.cpu_wren && is_stat) ovf_d = 1'b0;
        if (drop)                    ovf_d = 1'b1;
        if (bus.cpu_wren && is_led)  leds_d = bus.cpu_wdata[15:0];
        if (bus.cpu_wren && is_tmr)  timer_d = bus.cpu_wdata;

        if (is_evt)  rd_val_d = {29'h0, count_q};
        if (is_led)  rd_val_d = {16'h0, leds_q};
        if (is_sw)   rd_val_d = {16'h0, sync2_q};
        if (is_tmr)  rd_val_d = timer_q;
        if (is_stat) rd_val_d = {29'h0, ovf_q, empty, full};
    end

    always_ff @(posedge clock) begin
        if (push && !reset) fifo_q[wr_ptr_q] <= bus.cpu_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
            leds_q    <= 16'h0;
            sync1_q   <= 16'h0;
            sync2_q   <= 16'h0;
            timer_q   <= 32'h0;
            sel_ram_q <= 1'b0;
            rd_val_q  <= 32'h0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            leds_q    <= leds_d;
            sync1_q   <= bus.switches;
            sync2_q   <= sync1_q;
            timer_q   <= timer_d;
            sel_ram_q <= sel_ram_d;
            rd_val_q  <= rd_val_d;
        end
    end

    assign bus.leds      = leds_q;
    assign bus.cpu_rdata = sel_ram_q ? bus.ram_q : rd_val_q;
endmodule

// File: doc/dmem_io_bridge.md
DMEM_IO_BRIDGE -- requirements
Module: dmem_io_bridge

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: `clock` input 1, master clock, all state updates on rising edge.
REQ-002 `reset` input 1: synchronous, active-high.
REQ-003 `cpu_addr` input 32: processor data-memory address (word address).
REQ-004 `cpu_wdata` input 32: processor store data.
REQ-005 `cpu_wren` input 1: processor store strobe, one cycle per store.
REQ-006 `cpu_rdata` output 32: load data returned to processor.
REQ-007 `ram_addr` output 12: data RAM address.
REQ-008 `ram_wdata` output 32: data RAM write data.
REQ-009 `ram_wren` output 1: data RAM write enable.
REQ-010 `ram_q` input 32: data RAM read data, valid one cycle after `ram_addr`.
REQ-011 `evt_data` output 32: event FIFO head word.
REQ-012 `evt_valid` output 1: FIFO non-empty.
REQ-013 `evt_ready` input 1: consumer pop strobe.
REQ-014 `leds` output 16: LED register.
REQ-015 `switches` input 16: asynchronous board switches.

Function
REQ-016 Address decode SHALL be: 0x0000–0x0FFF RAM; 0x1000 EVENT; 0x1001 LED; 0x1002 SWITCH; 0x1003 TIMER; 0x1004 STATUS. All other addresses read 0 and ignore writes.
REQ-017 `ram_addr` SHALL equal `cpu_addr[11:0]` and `ram_wdata` SHALL equal `cpu_wdata`, combinationally.
REQ-018 `ram_wren` SHALL equal `cpu_wren` only when the address decodes to RAM, else 0.
REQ-019 All reads SHALL have 1-cycle latency.
- The region select and register value are captured at the edge.
- `cpu_rdata` in cycle N+1 reflects the address of cycle N: `ram_q` for RAM, the captured register value otherwise.
REQ-020 A write to EVENT SHALL push `cpu_wdata` into a 4-deep FIFO. EVENT reads return the occupancy (0–4) zero-extended.
REQ-021 A push when the FIFO is full and no pop occurs SHALL be dropped and SHALL set the sticky STATUS overflow bit.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when full (occupancy unchanged) and when empty (push only; a pop while empty is ignored).
REQ-023 `evt_valid` SHALL assert the cycle after the first push into an empty FIFO (no fall-through).
REQ-024 `evt_data` SHALL present the oldest entry. A pop occurs on any cycle with `evt_valid` and `evt_ready` both high.
REQ-025 Read/write pointers SHALL wrap modulo 4; occupancy SHALL be held in a 3-bit count.
REQ-026 LED writes SHALL load `cpu_wdata[15:0]` into `leds`. LED reads return `leds` zero-extended.
REQ-027 `switches` SHALL pass through a 2-flop synchronizer; SWITCH reads return the synchronized value zero-extended. Writes are ignored.
REQ-028 TIMER SHALL be a 32-bit free-running counter, incrementing every cycle and wrapping 0xFFFFFFFF→0.
REQ-029 A TIMER write SHALL load `cpu_wdata` in place of the increment; the next cycle reads back exactly `cpu_wdata`.
REQ-030 STATUS SHALL read {29'b0, overflow, empty, full}.
REQ-031 Any STATUS write SHALL clear overflow. If a dropped push coincides, set wins.

Reset
REQ-032 On reset the block SHALL:
- clear FIFO pointers and count (`evt_valid`=0, `evt_data`=0);
- clear `leds`, TIMER, overflow, both synchronizer stages, and the registered read select;
- drive `cpu_rdata`=0 the cycle after reset.
REQ-033 Reset SHALL override any coincident push, pop or write. FIFO contents are discarded mid-operation.

Verification
REQ-034 RAM pass-through: store 0xDEADBEEF at 0x0010, then load 0x0010 → `ram_wren` pulses once and `cpu_rdata`=0xDEADBEEF one cycle after the load address.
REQ-035 FIFO fill/overflow: 5 pushes (values 1–5) with `evt_ready`=0 → STATUS=0x5, EVENT read=4, pops yield 1,2,3,4, then `evt_valid`=0.
REQ-036 Simultaneous push/pop when full: push 6 while popping → occupancy stays 4, overflow not set, 6 emerges last.
REQ-037 TIMER: write 0xFFFFFFFE, then read on the following cycles → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-038 Switches 0xA5A5 applied → SWITCH read returns 0x0000A5A5 no earlier than 2 cycles after the change; LED write 0x1234_5678 → `leds`=0x5678.
REQ-039 Reset mid-operation: reset with 3 FIFO entries, `leds`=0xFFFF, overflow set → all cleared next cycle and STATUS reads 0x2.
